subtractor_serial: RTL

Bit-serial unsigned subtractor: computes A − B one bit per clock, LSB first, through a single 1-bit full-subtractor cell, and reports a registered difference and borrow with a one-cycle Done pulse. It is the subtraction counterpart to the team's registered synchronous adder. It trades latency for area and sits behind a simple Start/Ready handshake so a controller FSM can sequence operations.

---
 rtl/subtractor_serial_pkg.sv | 36 +++
 rtl/subtractor_serial_full_subtractor.sv | 19 +
 rtl/subtractor_serial.sv | 118 +++++++++++
 3 files changed

// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and
// constant helpers used to size the bit counter.
package subtractor_serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Bits needed to hold values 0 .. value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v = v >>> 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/subtractor_serial_full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin, Bout set when the
// subtraction needs to borrow from the next bit.
module full_subtractor
    import subtractor_serial_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    logic a_xor_b;

    assign a_xor_b = A ^ B;
    assign D       = a_xor_b ^ Bin;
    assign Bout    = (~A & B) | (~a_xor_b & Bin);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: one bit of A - B per clock, LSB first,
// behind a Start/Ready handshake with a one-cycle Done pulse.
module subtractor_serial
    import subtractor_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int             CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] res_sr_reg;
    logic [WIDTH-1:0] res_shifted;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_run_reg;
    logic             borrow_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             shifting;
    logic             last_shift;

    full_subtractor u_cell (
        .A    (a_sr_reg[0]),
        .B    (b_sr_reg[0]),
        .Bin  (borrow_run_reg),
        .D    (cell_d),
        .Bout (cell_bout)
    );

    // Result register shifts right; the fresh difference bit enters at the MSB
    // so that after WIDTH shifts the LSB-first bits sit in natural order.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_shifted[gi] = res_sr_reg[gi+1];
        end
    endgenerate
    assign res_shifted[WIDTH-1] = cell_d;

    assign accept     = (state_reg == IDLE) && Start;
    assign shifting   = (state_reg == SHIFT);
    assign last_shift = shifting && (cnt_reg == LAST_CNT);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            res_sr_reg     <= '0;
            borrow_run_reg <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_reg     <= 1'b0;
        end else begin
            if (accept) begin
                a_sr_reg       <= A;
                b_sr_reg       <= B;
                res_sr_reg     <= '0;
                borrow_run_reg <= 1'b0;
                cnt_reg        <= '0;
            end
            if (shifting) begin
                a_sr_reg       <= a_sr_reg >> 1;
                b_sr_reg       <= b_sr_reg >> 1;
                res_sr_reg     <= res_shifted;
                borrow_run_reg <= cell_bout;
                cnt_reg        <= cnt_reg + CNT_ONE;
            end
            // Outputs only move on the completion edge and hold otherwise.
            if (last_shift) begin
                diff_reg   <= res_shifted;
                borrow_reg <= cell_bout;
            end
        end
    end

    assign Ready  = (state_reg == IDLE);
    assign Done   = (state_reg == DONE);
    assign Diff   = diff_reg;
    assign Borrow = borrow_reg;

endmodule
